// File: rtl/seq_ctrl.sv
// Instruction sequencer: steps fetch/decode/execute/memory/writeback from a one-hot phase input.
// Latency: strobes are combinational in the active phase; ir/pc/zflag/flags update at that phase's edge.
// Backpressure: none; an idle or multi-bit phase holds all state, and a halt freezes it until reset.
module seq_ctrl (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [4:0]  phase,
    input  logic [15:0] imem_data,
    input  logic        alu_zero,
    output logic [7:0]  imem_addr,
    output logic [15:0] ir,
    output logic [3:0]  rd_sel,
    output logic [3:0]  rs_sel,
    output logic [3:0]  rt_sel,
    output logic [7:0]  imm,
    output logic        alu_en,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic        reg_we,
    output logic        hlt,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [3:0] OP_ALU = 4'd1;
    localparam logic [3:0] OP_LDI = 4'd2;
    localparam logic [3:0] OP_LD  = 4'd3;
    localparam logic [3:0] OP_ST  = 4'd4;
    localparam logic [3:0] OP_JMP = 4'd5;
    localparam logic [3:0] OP_BZ  = 4'd6;
    localparam logic [3:0] OP_HLT = 4'd7;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        zflag_q, zflag_d;
    logic        illegal_q, illegal_d;

    logic        phase_one_hot;
    logic        phase_multi;
    logic [3:0]  opcode;
    logic [7:0]  pc_inc;

    assign phase_one_hot = (phase != 5'd0) && ((phase & (phase - 5'd1)) == 5'd0);
    assign phase_multi   = (phase != 5'd0) && !phase_one_hot;
    assign opcode        = ir_q[15:12];
    assign pc_inc        = pc_q + 8'd1;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= 8'h00;
            ir_q      <= 16'h0000;
            zflag_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            zflag_q   <= zflag_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        zflag_d   = zflag_q;
        illegal_d = illegal_q;
        alu_en    = 1'b0;
        dmem_re   = 1'b0;
        dmem_we   = 1'b0;
        reg_we    = 1'b0;
        hlt       = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_RUN: begin
                if (phase_multi) begin
                    illegal_d = 1'b1;
                end
                if (phase_one_hot) begin
                    state_d = ST_RUN;
                    if (phase[0]) begin
                        ir_d = imem_data;
                    end else if (phase[1]) begin
                        // Opcodes 8-15 are flagged here and then fall through as NOPs.
                        if (opcode[3]) begin
                            illegal_d = 1'b1;
                        end
                    end else if (phase[2]) begin
                        if (opcode == OP_ALU) begin
                            alu_en  = 1'b1;
                            zflag_d = alu_zero;
                        end
                    end else if (phase[3]) begin
                        dmem_re = (opcode == OP_LD);
                        dmem_we = (opcode == OP_ST);
                    end else begin
                        reg_we = (opcode == OP_ALU) || (opcode == OP_LDI) || (opcode == OP_LD);
                        case (opcode)
                            OP_JMP:  pc_d = ir_q[7:0];
                            OP_BZ:   pc_d = zflag_q ? ir_q[7:0] : pc_inc;
                            OP_HLT: begin
                                hlt     = 1'b1;
                                state_d = ST_HALTED;
                            end
                            default: pc_d = pc_inc;
                        endcase
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign rd_sel    = ir_q[11:8];
    assign rs_sel    = ir_q[7:4];
    assign rt_sel    = ir_q[3:0];
    assign imm       = ir_q[7:0];
    assign halted    = (state_q == ST_HALTED);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: walks instructions through all five phases and checks strobes and state.
module tb_seq_ctrl;

    logic        clk;
    logic        n_rst;
    logic [4:0]  phase;
    logic [15:0] imem_data;
    logic        alu_zero;
    logic [7:0]  imem_addr;
    logic [15:0] ir;
    logic [3:0]  rd_sel, rs_sel, rt_sel;
    logic [7:0]  imm;
    logic        alu_en, dmem_re, dmem_we, reg_we, hlt, halted, illegal;
    logic [4:0]  strb;

    int errors = 0;
    int checks = 0;

    seq_ctrl dut (
        .clk(clk), .n_rst(n_rst), .phase(phase), .imem_data(imem_data), .alu_zero(alu_zero),
        .imem_addr(imem_addr), .ir(ir), .rd_sel(rd_sel), .rs_sel(rs_sel), .rt_sel(rt_sel),
        .imm(imm), .alu_en(alu_en), .dmem_re(dmem_re), .dmem_we(dmem_we), .reg_we(reg_we),
        .hlt(hlt), .halted(halted), .illegal(illegal)
    );

    assign strb = {alu_en, dmem_re, dmem_we, reg_we, hlt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {alu_en, dmem_re, dmem_we, reg_we, hlt} for opcode op in phase index i (not halted).
    function automatic logic [4:0] exp_strb(input logic [3:0] op, input int i);
        logic [4:0] e;
        e = 5'b0;
        e[4] = (i == 2) && (op == 4'd1);
        e[3] = (i == 3) && (op == 4'd3);
        e[2] = (i == 3) && (op == 4'd4);
        e[1] = (i == 4) && (op == 4'd1 || op == 4'd2 || op == 4'd3);
        e[0] = (i == 4) && (op == 4'd7);
        return e;
    endfunction

    task automatic drive(input logic [4:0] p, input logic [15:0] d, input logic az);
        @(negedge clk);
        phase = p; imem_data = d; alu_zero = az;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        n_rst = 1'b0;
        drive(5'd0, 16'h0000, 1'b0);
        tick;
        n_rst = 1'b1;
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        drive(5'd0, 16'h0000, 1'b0);
        tick; tick;
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h exp=00", imem_addr); end
        checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir got=%h exp=0000", ir); end
        checks++; if ({halted, illegal} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {halted, illegal}); end
        checks++; if (strb !== 5'b0) begin errors++; $display("FAIL reset_strobes got=%b exp=00000", strb); end
        n_rst = 1'b1;
    endtask

    task automatic test_ldi;
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL ldi_first_addr got=%h exp=00", imem_addr); end
        for (int i = 0; i < 5; i++) begin
            drive(5'(1 << i), 16'h2305, 1'b0);
            checks++; if (strb !== exp_strb(4'd2, i)) begin errors++; $display("FAIL ldi_strb[%0d] got=%b exp=%b", i, strb, exp_strb(4'd2, i)); end
            tick;
            if (i == 0) begin
                checks++; if ({ir, rd_sel, imm} !== {16'h2305, 4'h3, 8'h05}) begin errors++; $display("FAIL ldi_fields got=%h/%h/%h exp=2305/3/05", ir, rd_sel, imm); end
            end
        end
        checks++; if (imem_addr !== 8'h01) begin errors++; $display("FAIL ldi_pc got=%h exp=01", imem_addr); end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 5; i++) begin
            drive(5'(1 << i), 16'h50FF, 1'b0);
            checks++; if (strb !== exp_strb(4'd5, i)) begin errors++; $display("FAIL jmp_strb[%0d] got=%b exp=%b", i, strb, exp_strb(4'd5, i)); end
            tick;
        end
        checks++; if (imem_addr !== 8'hFF) begin errors++; $display("FAIL jmp_pc got=%h exp=ff", imem_addr); end
        for (int i = 0; i < 5; i++) begin
            drive(5'(1 << i), 16'h0000, 1'b0);
            tick;
        end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_pc got=%h exp=00", imem_addr); end
    endtask

    task automatic test_branch;
        logic [15:0] prog [5];
        logic        az   [5];
        logic [7:0]  pcx  [5];
        int          pulses;
        prog = '{16'h1123, 16'h6040, 16'h6080, 16'h1123, 16'h6040};
        az   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        pcx  = '{8'h01, 8'h40, 8'h80, 8'h81, 8'h82};
        for (int k = 0; k < 5; k++) begin
            pulses = 0;
            for (int i = 0; i < 5; i++) begin
                drive(5'(1 << i), prog[k], az[k]);
                checks++; if (strb !== exp_strb(prog[k][15:12], i)) begin errors++; $display("FAIL br%0d_strb[%0d] got=%b exp=%b", k, i, strb, exp_strb(prog[k][15:12], i)); end
                pulses += int'(alu_en);
                tick;
            end
            if (prog[k][15:12] == 4'd1) begin
                checks++; if (pulses != 1) begin errors++; $display("FAIL br%0d_alu_pulses got=%0d exp=1", k, pulses); end
            end
            checks++; if (imem_addr !== pcx[k]) begin errors++; $display("FAIL br%0d_pc got=%h exp=%h", k, imem_addr, pcx[k]); end
        end
    endtask

    task automatic test_mem;
        for (int i = 0; i < 5; i++) begin
            drive(5'(1 << i), 16'h3012, 1'b0);
            checks++; if (strb !== exp_strb(4'd3, i)) begin errors++; $display("FAIL ld_strb[%0d] got=%b exp=%b", i, strb, exp_strb(4'd3, i)); end
            tick;
        end
        checks++; if (imm !== 8'h12) begin errors++; $display("FAIL ld_imm got=%h exp=12", imm); end
        for (int i = 0; i < 5; i++) begin
            drive(5'(1 << i), 16'h4034, 1'b0);
            checks++; if (strb !== exp_strb(4'd4, i)) begin errors++; $display("FAIL st_strb[%0d] got=%b exp=%b", i, strb, exp_strb(4'd4, i)); end
            tick;
        end
        checks++; if (imem_addr !== 8'h84) begin errors++; $display("FAIL mem_pc got=%h exp=84", imem_addr); end
    endtask

    task automatic test_halt;
        for (int i = 0; i < 5; i++) begin
            drive(5'(1 << i), 16'h7000, 1'b0);
            checks++; if (strb !== exp_strb(4'd7, i)) begin errors++; $display("FAIL hlt_strb[%0d] got=%b exp=%b", i, strb, exp_strb(4'd7, i)); end
            tick;
        end
        checks++; if ({halted, imem_addr} !== {1'b1, 8'h84}) begin errors++; $display("FAIL hlt_state got=%b/%h exp=1/84", halted, imem_addr); end
        for (int i = 0; i < 5; i++) begin
            drive(5'(1 << i), 16'h2111, 1'b1);
            checks++; if (strb !== 5'b0) begin errors++; $display("FAIL halted_strb[%0d] got=%b exp=00000", i, strb); end
            tick;
        end
        checks++; if ({ir, imem_addr, halted} !== {16'h7000, 8'h84, 1'b1}) begin errors++; $display("FAIL halted_frozen got=%h/%h/%b exp=7000/84/1", ir, imem_addr, halted); end
    endtask

    task automatic test_illegal;
        do_reset;
        checks++; if ({halted, illegal} !== 2'b00) begin errors++; $display("FAIL ill_reset got=%b exp=00", {halted, illegal}); end
        for (int i = 0; i < 5; i++) begin
            drive(5'(1 << i), 16'hA000, 1'b0);
            checks++; if (strb !== 5'b0) begin errors++; $display("FAIL ill_strb[%0d] got=%b exp=00000", i, strb); end
            tick;
            if (i == 0) begin
                checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_early got=%b exp=0", illegal); end
            end
            if (i == 1) begin
                checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_decode got=%b exp=1", illegal); end
            end
        end
        checks++; if ({imem_addr, halted} !== {8'h01, 1'b0}) begin errors++; $display("FAIL ill_pc got=%h/%b exp=01/0", imem_addr, halted); end
        do_reset;
        drive(5'b00011, 16'h2111, 1'b0);
        tick;
        checks++; if ({ir, imem_addr, illegal} !== {16'h0000, 8'h00, 1'b1}) begin errors++; $display("FAIL multi_phase got=%h/%h/%b exp=0000/00/1", ir, imem_addr, illegal); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        for (int i = 0; i < 5; i++) begin
            drive(5'(1 << i), 16'h0000, 1'b0);
            tick;
        end
        for (int i = 0; i < 3; i++) begin
            drive(5'(1 << i), 16'h4034, 1'b0);
            tick;
        end
        drive(5'b01000, 16'h4034, 1'b0);
        checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL mid_we_before got=%b exp=1", dmem_we); end
        n_rst = 1'b0;
        tick;
        checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL mid_we_after got=%b exp=0", dmem_we); end
        checks++; if ({imem_addr, ir, halted, illegal} !== {8'h00, 16'h0000, 2'b00}) begin errors++; $display("FAIL mid_state got=%h/%h/%b/%b exp=00/0000/0/0", imem_addr, ir, halted, illegal); end
        n_rst = 1'b1;
        drive(5'd0, 16'h2222, 1'b0);
        tick;
        checks++; if ({imem_addr, ir} !== {8'h00, 16'h0000}) begin errors++; $display("FAIL idle_hold got=%h/%h exp=00/0000", imem_addr, ir); end
        drive(5'b00001, 16'h5077, 1'b0);
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL refetch_addr got=%h exp=00", imem_addr); end
        tick;
        checks++; if (ir !== 16'h5077) begin errors++; $display("FAIL refetch_ir got=%h exp=5077", ir); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0; phase = 5'd0; imem_data = 16'h0000; alu_zero = 1'b0;
        test_reset;
        test_ldi;
        test_wrap;
        test_branch;
        test_mem;
        test_halt;
        test_illegal;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
